// File: rtl/mux_rr_stage_pkg.sv
// Shared definitions for the registered fan-in multiplexer.
// Selection mode encodings, matching the 1-bit mode port.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_rr_stage_rr_pick.sv
// Combinational rotating priority encoder: first asserted req at or after ptr, wrapping mod N.
module rr_pick #(
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int unsigned ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    if (sum >= 32'(N)) sum = sum - 32'(N);
    return SELW'(sum);
  endfunction

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_vld && req[wrap_add(ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_add(ptr, k);
      end
    end
  end

endmodule

// File: rtl/mux_rr_stage.sv
// N-channel registered mux with valid/ready, fixed or round-robin selection.
// Optional MUX_RR_SELCHK_EN adds a registered sel_err flag for out-of-range sel.
module mux_rr_stage
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready
`ifdef MUX_RR_SELCHK_EN
  ,
  output logic            sel_err
`endif
);

  logic [SELW-1:0] rr_ptr;
  logic            load;
  logic            sel_ok;
  logic            rr_vld;
  logic [SELW-1:0] rr_idx;
  logic            gnt_vld;
  logic [SELW-1:0] g;
  logic [W-1:0]    ch_data [N];

  assign load   = !out_valid || out_ready;
  assign sel_ok = 32'(sel) < 32'(N);

  rr_pick #(.N(N)) u_pick (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  always_comb begin
    for (int unsigned i = 0; i < N; i++) ch_data[i] = in_data[i*W +: W];
  end

  always_comb begin
    gnt_vld = 1'b0;
    g       = '0;
    if (mode == MODE_RR) begin
      gnt_vld = rr_vld;
      g       = rr_idx;
    end else if (sel_ok) begin
      gnt_vld = in_valid[sel];
      g       = sel;
    end
  end

  // Gated by rst_n so no producer sees a handshake while reset is held.
  always_comb begin
    in_ready = '0;
    if (rst_n && load && gnt_vld) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (gnt_vld) begin
        out_data  <= ch_data[g];
        out_ch    <= g;
        out_valid <= 1'b1;
        if (mode == MODE_RR) rr_ptr <= (g == SELW'(N - 1)) ? '0 : g + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_RR_SELCHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= (mode == MODE_FIXED) && !sel_ok;
  end
`endif

endmodule

// File: tb/tb_mux_rr_stage.sv
// Directed self-checking bench for mux_rr_stage (N=4 main instance, N=3 for out-of-range sel).
module tb_mux_rr_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  int         tests = 0;
  int         failed = 0;

  logic       mode, out_ready, out_valid;
  logic [1:0] sel, out_data, out_ch;
  logic [7:0] in_data;
  logic [3:0] in_valid, in_ready;

  logic       mode3, out_ready3, out_valid3;
  logic [1:0] sel3, out_data3, out_ch3;
  logic [5:0] in_data3;
  logic [2:0] in_valid3, in_ready3;
`ifdef MUX_RR_SELCHK_EN
  logic       sel_err, sel_err3;
`endif

  always #5 clk = ~clk;

  mux_rr_stage #(.N(4), .W(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_RR_SELCHK_EN
    , .sel_err(sel_err)
`endif
  );

  mux_rr_stage #(.N(3), .W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3), .out_ch(out_ch3),
    .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUX_RR_SELCHK_EN
    , .sel_err(sel_err3)
`endif
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_data = 8'hFF; in_valid = 4'b1111; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_data3 = '0; in_valid3 = 3'b000; out_ready3 = 1'b1;
    #2;
    tests++;
    if (in_ready !== 4'b0000) begin failed++; $display("FAIL reset_in_ready_async got=%b exp=0000", in_ready); end
    tick(); tick();
    tests++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++;
    if (out_data !== 2'b00) begin failed++; $display("FAIL reset_out_data got=%b exp=00", out_data); end
    tests++;
    if (out_ch !== 2'd0) begin failed++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
    tests++;
    if (in_ready !== 4'b0000) begin failed++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
`ifdef MUX_RR_SELCHK_EN
    tests++;
    if (sel_err !== 1'b0) begin failed++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
`endif
    in_valid = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd2; in_data = 8'b00_11_00_00; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0100) begin failed++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
    tick();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 2'b11})
      begin failed++; $display("FAIL fixed_out got v/ch/d=%b/%0d/%b exp=1/2/11", out_valid, out_ch, out_data); end
    // drain: no valid input -> out_valid drops, data/ch hold
    in_valid = 4'b0000;
    tick();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b0, 2'd2, 2'b11})
      begin failed++; $display("FAIL fixed_drain got v/ch/d=%b/%0d/%b exp=0/2/11", out_valid, out_ch, out_data); end
  endtask

  task automatic test_rr();
    logic [1:0] e;
    mode = 1'b1; in_data = 8'b11_10_01_00; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = 2'(k % 4);
      #1;
      tests++;
      if (in_ready !== (4'b0001 << e)) begin failed++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", k, in_ready, 4'b0001 << e); end
      tick();
      tests++;
      if ({out_valid, out_ch, out_data} !== {1'b1, e, e})
        begin failed++; $display("FAIL rr_out[%0d] got v/ch/d=%b/%0d/%0d exp=1/%0d/%0d", k, out_valid, out_ch, out_data, e, e); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_data = 8'b00_01_10_11;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin mode = 1'b0; sel = 2'd3; end
      if (k == 2) mode = 1'b1;
      #1;
      tests++;
      if (in_ready !== 4'b0000) begin failed++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", k, in_ready); end
      tick();
      tests++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 2'd0})
        begin failed++; $display("FAIL bp_hold[%0d] got v/ch/d=%b/%0d/%0d exp=1/0/0", k, out_valid, out_ch, out_data); end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0010) begin failed++; $display("FAIL bp_release_in_ready got=%b exp=0010", in_ready); end
    tick();
    tests++;
    if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 2'b10})
      begin failed++; $display("FAIL bp_release_out got v/ch/d=%b/%0d/%b exp=1/1/10", out_valid, out_ch, out_data); end
  endtask

  task automatic test_rr_skip();
    logic [1:0] ech [4];
    logic [1:0] edat [4];
    ech  = '{2'd0, 2'd3, 2'd0, 2'd3};
    edat = '{2'd3, 2'd0, 2'd3, 2'd0};
    for (int k = 0; k < 4; k++) begin
      in_valid = (k == 0) ? 4'b0001 : 4'b1001;
      #1;
      tests++;
      if (in_ready !== (4'b0001 << ech[k])) begin failed++; $display("FAIL skip_in_ready[%0d] got=%b exp=%b", k, in_ready, 4'b0001 << ech[k]); end
      tick();
      tests++;
      if ({out_valid, out_ch, out_data} !== {1'b1, ech[k], edat[k]})
        begin failed++; $display("FAIL skip_out[%0d] got v/ch/d=%b/%0d/%0d exp=1/%0d/%0d", k, out_valid, out_ch, out_data, ech[k], edat[k]); end
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_sel_oob();
    mode3 = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111; in_data3 = 6'b10_01_00; out_ready3 = 1'b1;
    #1;
    tests++;
    if (in_ready3 !== 3'b010) begin failed++; $display("FAIL oob_pre_in_ready got=%b exp=010", in_ready3); end
    tick();
    tests++;
    if ({out_valid3, out_ch3, out_data3} !== {1'b1, 2'd1, 2'b01})
      begin failed++; $display("FAIL oob_pre_out got v/ch/d=%b/%0d/%b exp=1/1/01", out_valid3, out_ch3, out_data3); end
    sel3 = 2'd3;
    #1;
    tests++;
    if (in_ready3 !== 3'b000) begin failed++; $display("FAIL oob_in_ready got=%b exp=000", in_ready3); end
    tick();
    tests++;
    if ({out_valid3, out_ch3, out_data3} !== {1'b0, 2'd1, 2'b01})
      begin failed++; $display("FAIL oob_out got v/ch/d=%b/%0d/%b exp=0/1/01", out_valid3, out_ch3, out_data3); end
`ifdef MUX_RR_SELCHK_EN
    tests++;
    if (sel_err3 !== 1'b1) begin failed++; $display("FAIL oob_sel_err got=%b exp=1", sel_err3); end
`endif
    sel3 = 2'd0;
    #1;
    tests++;
    if (in_ready3 !== 3'b001) begin failed++; $display("FAIL oob_recover_in_ready got=%b exp=001", in_ready3); end
    tick();
    tests++;
    if ({out_valid3, out_ch3, out_data3} !== {1'b1, 2'd0, 2'b00})
      begin failed++; $display("FAIL oob_recover_out got v/ch/d=%b/%0d/%b exp=1/0/00", out_valid3, out_ch3, out_data3); end
`ifdef MUX_RR_SELCHK_EN
    tests++;
    if (sel_err3 !== 1'b0) begin failed++; $display("FAIL oob_sel_err_clear got=%b exp=0", sel_err3); end
`endif
  endtask

  initial begin
    test_reset();
    tick();
    test_fixed();
    test_rr();
    test_backpressure();
    test_rr_skip();
    test_sel_oob();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
